// File: rtl/alu_seq_if.sv
// Bundle between alu_seq and its environment: the request/response pair
// seen by the requester plus the byte-wide ALU the sequencer borrows.
interface alu_seq_if;
    // request side
    logic        start;
    logic [1:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    // response side
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        c;
    logic        z;
    logic        err;
    // external ALU drive
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_cin;
    logic [1:0]  alu_shift;
    // external ALU response (combinational, same cycle)
    logic [7:0]  alu_result;
    logic        alu_cout;
    logic        alu_z;
    // current sequencer state for observation
    logic [2:0]  dbg_state;

    modport slave (
        input  start, op, x, y, alu_result, alu_cout, alu_z,
        output busy, done, result, c, z, err,
               alu_a, alu_b, alu_op, alu_cin, alu_shift, dbg_state
    );

    modport master (
        output start, op, x, y, alu_result, alu_cout, alu_z,
        input  busy, done, result, c, z, err,
               alu_a, alu_b, alu_op, alu_cin, alu_shift, dbg_state
    );
endinterface

// File: rtl/alu_seq.sv
// Sequencer that builds 16-bit add/subtract and an 8x8 unsigned multiply
// out of an external 8-bit ALU, one ALU operation per clock.
//
// Handshake: start/op/x/y form a request that is taken on a rising edge
// where start=1 and the block is in IDLE (busy=0, done=0); in any other
// state start is ignored. done is a one-cycle response strobe and
// result/c/z/err stay valid from then until the next accepted request.
module alu_seq (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_ADDC = 3'd1;
    localparam logic [2:0] ALU_SUBC = 3'd2;
    localparam logic [2:0] ALU_MOVR = 3'd3;

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [15:0] x_q, y_q;
    logic        carry_q, zlo_q;
    logic [7:0]  acc_q, lo_q, mcand_q;
    logic [2:0]  cnt_q;
    logic [15:0] result_q;
    logic        c_q, z_q, err_q;

    logic [7:0]  acc_d, lo_d;
    logic [15:0] prod_d;

    // Shift-add step: the ALU sum shifts right into acc, its LSB into lo.
    assign acc_d  = {bus.alu_cout, bus.alu_result[7:1]};
    assign lo_d   = {bus.alu_result[0], lo_q[7:1]};
    assign prod_d = {acc_d, lo_d};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode and ALU drive for the current state.
    always_comb begin
        state_d     = state_q;
        bus.alu_op  = ALU_MOVR;
        bus.alu_a   = 8'd0;
        bus.alu_b   = 8'd0;
        bus.alu_cin = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MUL:  state_d = S_MUL;
                        OP_ADD:  state_d = S_LO;
                        OP_SUB:  state_d = S_LO;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_LO: begin
                bus.alu_a  = x_q[7:0];
                bus.alu_b  = y_q[7:0];
                bus.alu_op = (op_q == OP_SUB) ? ALU_SUBC : ALU_ADD;
                state_d    = S_HI;
            end
            S_HI: begin
                bus.alu_a   = x_q[15:8];
                bus.alu_b   = y_q[15:8];
                bus.alu_op  = (op_q == OP_SUB) ? ALU_SUBC : ALU_ADDC;
                bus.alu_cin = carry_q;
                state_d     = S_DONE;
            end
            S_MUL: begin
                bus.alu_op = ALU_ADD;
                bus.alu_a  = acc_q;
                bus.alu_b  = lo_q[0] ? mcand_q : 8'd0;
                if (cnt_q == 3'd7) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-state result accumulation and flag update.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= 2'd0;
            x_q      <= 16'd0;
            y_q      <= 16'd0;
            carry_q  <= 1'b0;
            zlo_q    <= 1'b0;
            acc_q    <= 8'd0;
            lo_q     <= 8'd0;
            mcand_q  <= 8'd0;
            cnt_q    <= 3'd0;
            result_q <= 16'd0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.op;
                        x_q   <= bus.x;
                        y_q   <= bus.y;
                        err_q <= 1'b0;
                        if (bus.op == OP_MUL) begin
                            acc_q   <= 8'd0;
                            lo_q    <= bus.x[7:0];
                            mcand_q <= bus.y[7:0];
                            cnt_q   <= 3'd0;
                        end
                        if (bus.op == OP_RSV) begin
                            result_q <= 16'd0;
                            c_q      <= 1'b0;
                            z_q      <= 1'b1;
                            err_q    <= 1'b1;
                        end
                    end
                end
                S_LO: begin
                    result_q[7:0] <= bus.alu_result;
                    carry_q       <= bus.alu_cout;
                    zlo_q         <= bus.alu_z;
                end
                S_HI: begin
                    result_q[15:8] <= bus.alu_result;
                    c_q            <= bus.alu_cout;
                    z_q            <= zlo_q & bus.alu_z;
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        result_q <= prod_d;
                        c_q      <= 1'b0;
                        z_q      <= (prod_d == 16'd0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_MUL);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.c         = c_q;
    assign bus.z         = z_q;
    assign bus.err       = err_q;
    assign bus.alu_shift = 2'b00;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: supplies a behavioural byte ALU, runs a table of
// directed vectors, hand-written reset/abort sequences and random traffic.
module tb_alu_seq;

    logic clk;
    logic rst;
    alu_seq_if bus();

    alu_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural byte ALU: ADD ignores carry-in, SUBC returns borrow as cout.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = 9'd0;
        case (bus.alu_op)
            3'd0:    alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'd1:    alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_cin};
            3'd2:    alu_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'd0, bus.alu_cin};
            3'd3:    alu_wide = {1'b0, bus.alu_b};
            default: alu_wide = 9'd0;
        endcase
    end
    assign bus.alu_result = alu_wide[7:0];
    assign bus.alu_cout   = alu_wide[8];
    assign bus.alu_z      = (alu_wide[7:0] == 8'd0);

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [18:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the whole operands, packed {result,c,z,err}.
    function automatic logic [18:0] ref_model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        logic [15:0] r16;
        r = 32'd0;
        case (o)
            2'b00: begin
                r = 32'(a[7:0]) * 32'(b[7:0]);
                r16 = r[15:0];
                return {r16, 1'b0, (r == 32'd0), 1'b0};
            end
            2'b01: begin
                r = 32'(a) + 32'(b);
                r16 = r[15:0];
                return {r16, (r > 32'h0000_FFFF), (r16 == 16'd0), 1'b0};
            end
            2'b10: begin
                r16 = a - b;
                return {r16, (a < b), (a == b), 1'b0};
            end
            default: return {16'd0, 1'b0, 1'b1, 1'b1};
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o);
        case (o)
            2'b00:   return 9;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    // driver: issue one request, follow it to done, score the response
    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input bit garble, input string name);
        int lat;
        int busy_n;
        logic exp_cin;
        logic [18:0] exp_v;
        logic [18:0] act_v;
        exp_cin = (o == 2'b10) ? (a[7:0] < b[7:0]) : ((9'(a[7:0]) + 9'(b[7:0])) > 9'd255);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.x     = a;
        bus.y     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = 16'($urandom);
        bus.y     = 16'($urandom);
        lat    = 1;
        busy_n = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busy_n++;
            if (o == 2'b01 || o == 2'b10) begin
                if (lat == 1) begin
                    chk({name, "_lo_alu_a"}, 32'(bus.alu_a), 32'(a[7:0]));
                    chk({name, "_lo_alu_b"}, 32'(bus.alu_b), 32'(b[7:0]));
                end
                if (lat == 2) begin
                    chk({name, "_hi_alu_op"}, 32'(bus.alu_op), (o == 2'b01) ? 32'd1 : 32'd2);
                    chk({name, "_hi_alu_cin"}, 32'(bus.alu_cin), 32'(exp_cin));
                end
            end
            if (garble) begin
                bus.start = 1'b1;
                bus.op    = 2'($urandom_range(1, 3));
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        chk({name, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
        act_v = {bus.result, bus.c, bus.z, bus.err};
        chk({name, "_result_c_z_err"}, 32'(act_v), 32'(exp_v));
        @(negedge clk);
        chk({name, "_done_pulse_len"}, 32'(bus.done), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        err;
        int          lat;
        bit          garble;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int dones;
        vecs[0] = '{2'b01, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 3, 1'b0};
        vecs[1] = '{2'b01, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 3, 1'b0};
        vecs[2] = '{2'b10, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 3, 1'b0};
        vecs[3] = '{2'b00, 16'hA5FF, 16'h3CFF, 16'hFE01, 1'b0, 1'b0, 1'b0, 9, 1'b0};
        vecs[4] = '{2'b00, 16'h0000, 16'h0037, 16'h0000, 1'b0, 1'b1, 1'b0, 9, 1'b1};
        vecs[5] = '{2'b11, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b1, 1, 1'b0};
        vecs[6] = '{2'b01, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 3, 1'b0};
        vecs[7] = '{2'b10, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 3, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.x     = 16'd0;
        bus.y     = 16'd0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_flags", 32'({bus.result, bus.c, bus.z, bus.err}), 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd3);
        chk("rst_alu_ab_cin", 32'({bus.alu_a, bus.alu_b, bus.alu_cin}), 32'd0);
        chk("rst_alu_shift", 32'(bus.alu_shift), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_alu_op", 32'(bus.alu_op), 32'd3);

        // table of directed vectors
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].err});
            do_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].lat, vecs[i].garble, $sformatf("vec%0d", i));
        end

        // reserved op sets err, the following accepted start clears it immediately
        exp_q.push_back(ref_model(2'b11, 16'h0, 16'h0));
        do_op(2'b11, 16'h0, 16'h0, 1, 1'b0, "rsv_again");
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.x     = 16'h0001;
        bus.y     = 16'h0002;
        @(negedge clk);
        bus.start = 1'b0;
        chk("err_cleared_on_accept", 32'(bus.err), 32'd0);
        repeat (4) @(negedge clk);

        // reset during MUL iteration 4, with a start in the reset cycle
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.x     = 16'h00FF;
        bus.y     = 16'h00FF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_in_mul_busy", 32'(bus.busy), 32'd1);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'b01;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_alu_op", 32'(bus.alu_op), 32'd3);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
            @(negedge clk);
        end
        chk("abort_no_done_or_start", 32'(dones), 32'd0);
        exp_q.push_back(ref_model(2'b01, 16'h1234, 16'h1111));
        do_op(2'b01, 16'h1234, 16'h1111, 3, 1'b0, "after_abort_add");

        // random traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [15:0] a;
            logic [15:0] b;
            o = 2'($urandom_range(0, 3));
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 7 == 0) b = a;
            exp_q.push_back(ref_model(o, a, b));
            do_op(o, a, b, ref_lat(o), (i % 3 == 0), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  00=MUL (8x8 unsigned), 01=ADD16, 10=SUB16, 11=reserved.
REQ-006 x, y  input  16 each  operands; MUL uses x[7:0], y[7:0]; captured when start is accepted.
REQ-007 busy  output  1  high in LO, HI and MUL states.
REQ-008 done  output  1  one-cycle pulse in DONE state.
REQ-009 result  output  16  final value; held from DONE until the next accepted start.
REQ-010 c, z, err  output  1 each  final carry/borrow, final zero, reserved-op flag; held like result.
REQ-011 alu_a, alu_b  output  8 each  ALU operands.
REQ-012 alu_op  output  3  ALU opcode: 0=ADD, 1=ADDC, 2=SUBC, 3=MOVR.
REQ-013 alu_cin, alu_shift  output  1, 2  ALU carry-in, ALU shift select.
REQ-014 alu_result, alu_cout, alu_z  input  8, 1, 1  combinational ALU response in the same cycle.

Function
REQ-015 States SHALL be IDLE, LO, HI, MUL and DONE.
REQ-016 In IDLE with start=1: op 01/10 -> LO; op 00 -> MUL with iteration counter 0; op 11 -> DONE with result=0, c=0, z=1, err=1.
REQ-017 When start is accepted, the block SHALL clear err and latch x, y and op.
REQ-018 start SHALL be ignored in every state except IDLE.
REQ-019 LO drives alu_a=x[7:0] and alu_b=y[7:0]: ADD16 uses alu_op=ADD, alu_cin=0; SUB16 uses alu_op=SUBC, alu_cin=0. It latches result[7:0]=alu_result, carry=alu_cout and zlo=alu_z, then goes to HI.
REQ-020 HI drives alu_a=x[15:8] and alu_b=y[15:8]: ADD16 uses alu_op=ADDC; SUB16 uses SUBC; alu_cin=latched carry. It latches result[15:8]=alu_result, c=alu_cout and z=zlo AND alu_z, then goes to DONE.
REQ-021 SUB16 c SHALL be the borrow: c=1 iff x<y unsigned.
REQ-022 MUL initialises accumulator acc=0, lo=x[7:0] and mcand=y[7:0].
REQ-023 Each MUL cycle drives alu_op=ADD, alu_a=acc, alu_b=(lo[0] ? mcand : 0), alu_cin=0.
REQ-024 Each MUL cycle updates acc={alu_cout, alu_result[7:1]} and lo={alu_result[0], lo[7:1]}, and increments the counter.
REQ-025 After the eighth MUL cycle (counter 7) the block SHALL go to DONE with result={acc,lo}, c=0, z=(product==0) computed locally.
REQ-026 DONE asserts done=1 and busy=0, then returns to IDLE unconditionally.
REQ-027 Latency, with start accepted at edge N: ADD16/SUB16 done in cycle N+3; MUL done in cycle N+9; reserved op done in cycle N+1.
REQ-028 alu_shift SHALL be 2'b00 in all states.
REQ-029 In IDLE and DONE the ALU outputs SHALL be alu_op=MOVR, alu_a=0, alu_b=0, alu_cin=0.
REQ-030 Arithmetic SHALL be modulo 2^16 for ADD16/SUB16 and exact for MUL (maximum 0xFE01).
REQ-031 Operand changes on x/y after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-032 rst=1 at a rising edge SHALL force IDLE in the next cycle from any state, including mid-operation.
REQ-033 Reset SHALL clear busy, done, result, c, z, err, acc, lo, the counter and all latched operands to 0.
REQ-034 During and after reset, ALU outputs SHALL follow REQ-029.
REQ-035 A start asserted in the same cycle as rst SHALL be discarded.
REQ-036 An operation aborted by reset SHALL NOT produce a done pulse.

Verification
REQ-037 ADD16 x=0x00FF, y=0x0001 -> done in cycle N+3; result=0x0100, c=0, z=0, err=0; ADDC seen with alu_cin=1 in HI.
REQ-038 ADD16 x=0xFFFF, y=0x0001 -> result=0x0000, c=1, z=1; SUB16 x=0x0000, y=0x0001 -> result=0xFFFF, c=1, z=0.
REQ-039 MUL x=0x00FF, y=0x00FF -> busy for 8 cycles, done in cycle N+9, result=0xFE01, c=0, z=0; x[15:8]/y[15:8] garbage ignored.
REQ-040 MUL x=0x0000, y=0x0037 -> result=0x0000, z=1; start pulses with a different op during busy are ignored and result is unchanged.
REQ-041 rst asserted at MUL iteration 4 -> next cycle IDLE, busy=0, result=0, no done pulse; a subsequent ADD16 0x1234+0x1111 -> 0x2345.
REQ-042 op=11 -> done in cycle N+1, err=1, result=0, z=1; the next accepted start clears err.
